fir_axis_out: RTL and testbench

//  Output stage placed directly after the FIR datapath. It qualifies each FIR output with a delayed enable and discards pipeline-fill samples.
//  It saturates the 32-bit FIR result to Q1.15, buffers it in a small FIFO and drives an AXI4-Stream master with framed TLAST.
//  It also raises stall back to the FIR input side so that no sample is lost under TREADY backpressure.

---
 rtl/fir_axis_out_pkg.sv | 42 ++++
 rtl/fir_out_fifo.sv | 75 +++++++
 rtl/fir_axis_out.sv | 124 ++++++++++++
 tb/tb_fir_axis_out.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_axis_out_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : fir_axis_out_pkg                                           |
// | Shared constants, types and the Q1.15 saturator for the FIR          |
// | AXI4-Stream output stage.                                            |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
package fir_axis_out_pkg;

  localparam logic [15:0] Q15_MAX       = 16'h7FFF;
  localparam logic [15:0] Q15_MIN       = 16'h8000;
  localparam int          FIR_TAPS      = 6;
  localparam int          FIR_FRAME_LEN = 64;

  // One FIFO entry: TLAST travels with its sample as the 17th bit.
  typedef struct packed {
    logic        last;
    logic [15:0] data;
  } axis_word_t;

  typedef struct packed {
    logic        clip;
    logic [15:0] data;
  } sat_t;

  function automatic sat_t sat_q15(input logic signed [31:0] y);
    sat_t r;
    if (y > 32'sd32767) begin
      r.clip = 1'b1;
      r.data = Q15_MAX;
    end else if (y < -32'sd32768) begin
      r.clip = 1'b1;
      r.data = Q15_MIN;
    end else begin
      r.clip = 1'b0;
      r.data = y[15:0];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_out_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fir_out_fifo                                               |
// | Synchronous first-word-fall-through FIFO, depth 2**FIFO_AW.          |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
// | clk, rst_n : clock, asynchronous active-low reset                    |
// | clr        : synchronous clear, wins over push and pop               |
// | push, din  : write request and data (ignored when full w/o pop)      |
// | pop        : read request (ignored when empty)                       |
// | dout       : head entry, zero while empty                            |
// | empty,full : status                                                  |
// | level      : occupancy, FIFO_AW+1 bits                                |
// +----------------------------------------------------------------------+
module fir_out_fifo #(
  parameter int WIDTH   = 17,
  parameter int FIFO_AW = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               push,
  input  logic [WIDTH-1:0]   din,
  input  logic               pop,
  output logic [WIDTH-1:0]   dout,
  output logic               empty,
  output logic               full,
  output logic [FIFO_AW:0]   level
);

  localparam int              DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_LVL = {1'b1, {FIFO_AW{1'b0}}};

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign empty   = (level == '0);
  assign full    = (level == FULL_LVL);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is fine then.
  assign do_push = push && (!full || do_pop);
  // Gate the head so an idle or flushed FIFO presents zero data.
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !clr) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/fir_axis_out.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fir_axis_out                                               |
// | FIR output stage: drops pipeline-fill samples, saturates to Q1.15,   |
// | buffers in a FIFO and drives an AXI4-Stream master with framed TLAST.|
// | Raises stall so the FIR input side can avoid FIFO overflow.          |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
// | clk, rst_n     : clock, asynchronous active-low reset                |
// | flush          : sync clear of FIFO, prime/frame counters and flags  |
// | fir_en         : enable driven into the FIR this cycle               |
// | fir_y          : signed 32-bit FIR result, valid the cycle after en  |
// | stall          : upstream must hold fir_en low while set             |
// | m_axis_*       : AXI4-Stream master (tdata Q1.15, tvalid, tready,    |
// |                  tlast)                                              |
// | sat_flag       : sticky, a sample was clipped                        |
// | ovf_flag       : sticky, a sample was dropped on a full FIFO         |
// +----------------------------------------------------------------------+
module fir_axis_out
  import fir_axis_out_pkg::*;
#(
  parameter int PIPE_LAT  = FIR_TAPS,
  parameter int FIFO_AW   = 3,
  parameter int FRAME_LEN = FIR_FRAME_LEN
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               fir_en,
  input  logic signed [31:0] fir_y,
  output logic               stall,
  output logic [15:0]        m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast,
  output logic               sat_flag,
  output logic               ovf_flag
);

  localparam int               DEPTH      = 1 << FIFO_AW;
  localparam int               PW         = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);
  localparam logic [PW-1:0]    PRIME_DONE = PW'(PIPE_LAT);
  localparam logic [15:0]      FRAME_LAST = 16'(FRAME_LEN - 1);
  localparam logic [FIFO_AW:0] STALL_LVL  = (FIFO_AW + 1)'(DEPTH - 2);

  logic              en_d;
  logic [PW-1:0]     prime_cnt;
  logic [15:0]       frame_cnt;
  logic              primed;
  logic              push;
  logic              pop;
  logic              accepted;
  logic              dropped;
  sat_t              sat;
  axis_word_t        fifo_din;
  axis_word_t        fifo_dout;
  logic              fifo_empty;
  logic              fifo_full;
  logic [FIFO_AW:0]  fifo_level;

  assign primed   = (prime_cnt == PRIME_DONE);
  assign push     = en_d && primed;
  assign pop      = m_axis_tvalid && m_axis_tready;
  assign accepted = push && (!fifo_full || pop);
  assign dropped  = push && fifo_full && !pop;
  assign sat      = sat_q15(fir_y);

  assign fifo_din.last = (frame_cnt == FRAME_LAST);
  assign fifo_din.data = sat.data;

  fir_out_fifo #(
    .WIDTH   ($bits(axis_word_t)),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_dout.data;
  assign m_axis_tlast  = fifo_dout.last;
  // Two slots of headroom: one sample already in en_d plus this cycle's en.
  assign stall         = (fifo_level >= STALL_LVL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_d <= 1'b0;
    end else begin
      en_d <= fir_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prime_cnt <= '0;
      frame_cnt <= '0;
      sat_flag  <= 1'b0;
      ovf_flag  <= 1'b0;
    end else if (flush) begin
      prime_cnt <= '0;
      frame_cnt <= '0;
      sat_flag  <= 1'b0;
      ovf_flag  <= 1'b0;
    end else begin
      if (en_d && !primed) prime_cnt <= prime_cnt + 1'b1;
      // Only samples that actually land in the FIFO advance the frame position.
      if (accepted) begin
        frame_cnt <= (frame_cnt == FRAME_LAST) ? 16'd0 : frame_cnt + 16'd1;
      end
      if (push && sat.clip) sat_flag <= 1'b1;
      if (dropped)          ovf_flag <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_axis_out.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_fir_axis_out                                            |
// | Self-checking bench for fir_axis_out with a scoreboard queue.        |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_fir_axis_out;

  localparam int PL    = 6;
  localparam int AW    = 3;
  localparam int FL    = 4;
  localparam int DEPTH = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               flush;
  logic               fir_en;
  logic signed [31:0] fir_y;
  logic               stall;
  logic [15:0]        tdata;
  logic               tvalid;
  logic               tready;
  logic               tlast;
  logic               sat_flag;
  logic               ovf_flag;

  always #5 clk = ~clk;

  fir_axis_out #(
    .PIPE_LAT  (PL),
    .FIFO_AW   (AW),
    .FRAME_LEN (FL)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .fir_en        (fir_en),
    .fir_y         (fir_y),
    .stall         (stall),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast),
    .sat_flag      (sat_flag),
    .ovf_flag      (ovf_flag)
  );

  int          total = 0;
  int          bad   = 0;
  logic [16:0] sbq[$];          // expected {tlast, tdata}
  int          m_prime;
  int          m_frame;
  bit          m_en;
  bit          m_sat;
  logic signed [31:0] y_pend;
  int          tlast_seen;
  bit          mon_on = 1'b0;
  bit          hold_prev = 1'b0;
  bit          flush_prev = 1'b0;
  logic [16:0] hold_word;
  logic [16:0] exp_w;

  function automatic logic [15:0] ref_sat(input logic signed [31:0] y, output bit clip);
    clip = 1'b1;
    if (y > 32767)       return 16'h7FFF;
    else if (y < -32768) return 16'h8000;
    clip = 1'b0;
    return y[15:0];
  endfunction

  // Scoreboard: every AXIS handshake must match the oldest expected entry.
  always @(negedge clk) begin
    if (mon_on) begin
      if (tvalid && tready) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat: got %h with nothing expected", {tlast, tdata});
        end else begin
          exp_w = sbq.pop_front();
          if ({tlast, tdata} !== exp_w) begin
            bad++;
            $display("FAIL beat: got last=%b data=%h want last=%b data=%h",
                     tlast, tdata, exp_w[16], exp_w[15:0]);
          end
          if (tlast) tlast_seen++;
        end
      end
      if (hold_prev && !flush_prev) begin
        total++;
        if (tvalid !== 1'b1 || {tlast, tdata} !== hold_word) begin
          bad++;
          $display("FAIL hold_stable: got v=%b %h want v=1 %h", tvalid, {tlast, tdata}, hold_word);
        end
      end
      hold_prev  = tvalid && !tready;
      hold_word  = {tlast, tdata};
      flush_prev = flush;
    end
  end

  // One clock of stimulus. Checks tvalid/stall against the model's occupancy,
  // then models the push the DUT commits at the end of this cycle.
  task automatic tick(input bit en, input logic signed [31:0] y, input bit rdy, input bit obey);
    bit          e;
    bit          clip;
    logic [15:0] d;
    @(posedge clk); #1;
    total++;
    if (tvalid !== (sbq.size() != 0)) begin
      bad++;
      $display("FAIL tvalid_track: got %b want %b", tvalid, sbq.size() != 0);
    end
    total++;
    if (stall !== (sbq.size() >= DEPTH - 2)) begin
      bad++;
      $display("FAIL stall_track: got %b want %b (occupancy %0d)", stall, sbq.size() >= DEPTH - 2, sbq.size());
    end
    if (m_en) begin
      if (m_prime < PL) begin
        m_prime++;
      end else begin
        d = ref_sat(y_pend, clip);
        if (clip) m_sat = 1'b1;
        if (!(sbq.size() == DEPTH && !rdy)) begin
          sbq.push_back({(m_frame == FL - 1), d});
          m_frame = (m_frame == FL - 1) ? 0 : m_frame + 1;
        end
      end
    end
    e      = obey ? (en && !stall) : en;
    fir_y  = y_pend;
    fir_en = e;
    tready = rdy;
    m_en   = e;
    y_pend = y;
  endtask

  task automatic prime(input bit rdy);
    for (int i = 0; i < PL; i++) tick(1'b1, 32'sd11111 + i, rdy, 1'b0);
  endtask

  task automatic drain();
    tick(1'b0, 0, 1'b1, 1'b0);
    tick(1'b0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 40 && sbq.size() != 0; i++) tick(1'b0, 0, 1'b1, 1'b0);
    tick(1'b0, 0, 1'b1, 1'b0);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: got %0d entries left want 0", sbq.size());
    end
  endtask

  task automatic do_flush();
    @(posedge clk); #1;
    flush  = 1'b1;
    fir_en = 1'b0;
    tready = 1'b0;
    fir_y  = y_pend;
    m_en   = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    sbq.delete();
    m_prime = 0;
    m_frame = 0;
    m_sat   = 1'b0;
    total++;
    if (tvalid !== 1'b0 || sat_flag !== 1'b0 || ovf_flag !== 1'b0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL flush_state: got v=%b sat=%b ovf=%b stall=%b want all 0", tvalid, sat_flag, ovf_flag, stall);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; fir_en = 1'b0; fir_y = 0; tready = 1'b0;
    m_prime = 0; m_frame = 0; m_en = 1'b0; m_sat = 1'b0; y_pend = 0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (tvalid !== 1'b0)    begin bad++; $display("FAIL rst_tvalid: got %b want 0", tvalid); end
    total++; if (tdata !== 16'h0)    begin bad++; $display("FAIL rst_tdata: got %h want 0000", tdata); end
    total++; if (tlast !== 1'b0)     begin bad++; $display("FAIL rst_tlast: got %b want 0", tlast); end
    total++; if (stall !== 1'b0)     begin bad++; $display("FAIL rst_stall: got %b want 0", stall); end
    total++; if (sat_flag !== 1'b0)  begin bad++; $display("FAIL rst_sat: got %b want 0", sat_flag); end
    total++; if (ovf_flag !== 1'b0)  begin bad++; $display("FAIL rst_ovf: got %b want 0", ovf_flag); end
    rst_n  = 1'b1;
    mon_on = 1'b1;
  endtask

  task automatic test_prime_latency();
    prime(1'b1);
    tick(1'b1, 777, 1'b1, 1'b0);          // cycle t
    tick(1'b0, 0, 1'b1, 1'b0);            // t+1
    total++;
    if (tvalid !== 1'b0) begin bad++; $display("FAIL lat_t1: got tvalid=%b want 0", tvalid); end
    tick(1'b0, 0, 1'b1, 1'b0);            // t+2
    total++;
    if (tvalid !== 1'b1 || tdata !== 16'h0309) begin
      bad++; $display("FAIL lat_t2: got v=%b data=%h want v=1 data=0309", tvalid, tdata);
    end
    drain();
  endtask

  task automatic test_saturation();
    do_flush();
    prime(1'b1);
    tick(1'b1, 32767, 1'b1, 1'b0);
    tick(1'b1, -32768, 1'b1, 1'b0);
    tick(1'b0, 0, 1'b1, 1'b0);
    tick(1'b0, 0, 1'b1, 1'b0);
    total++;
    if (sat_flag !== 1'b0) begin bad++; $display("FAIL sat_boundary: got %b want 0", sat_flag); end
    tick(1'b1, 40000, 1'b1, 1'b0);
    tick(1'b1, -40000, 1'b1, 1'b0);
    tick(1'b1, 1234, 1'b1, 1'b0);
    total++;
    if (sat_flag !== 1'b1) begin bad++; $display("FAIL sat_set: got %b want 1", sat_flag); end
    drain();
    total++;
    if (sat_flag !== 1'b1) begin bad++; $display("FAIL sat_sticky: got %b want 1", sat_flag); end
  endtask

  task automatic test_frames();
    do_flush();
    tlast_seen = 0;
    prime(1'b1);
    for (int i = 0; i < 3 * FL; i++) tick(1'b1, 100 * (i + 1), 1'b1, 1'b0);
    drain();
    total++;
    if (tlast_seen !== 3) begin bad++; $display("FAIL frame_count: got %0d want 3", tlast_seen); end
  endtask

  task automatic test_backpressure();
    do_flush();
    prime(1'b0);
    for (int i = 0; i < 20; i++) tick(1'b1, 5000 + i, 1'b0, 1'b1);
    total++;
    if (stall !== 1'b1 || tvalid !== 1'b1) begin
      bad++; $display("FAIL bp_stall: got stall=%b v=%b want 1 1", stall, tvalid);
    end
    total++;
    if (ovf_flag !== 1'b0) begin bad++; $display("FAIL bp_ovf: got %b want 0", ovf_flag); end
    drain();
  endtask

  task automatic test_overflow();
    do_flush();
    prime(1'b0);
    for (int i = 0; i < 20; i++) tick(1'b1, 9000 + i, 1'b0, 1'b0);
    tick(1'b0, 0, 1'b0, 1'b0);
    tick(1'b0, 0, 1'b0, 1'b0);
    total++;
    if (ovf_flag !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", ovf_flag); end
    total++;
    if (tdata !== 16'h2328) begin bad++; $display("FAIL ovf_head: got %h want 2328", tdata); end
    drain();
  endtask

  task automatic test_full_pushpop();
    do_flush();
    prime(1'b0);
    for (int i = 0; i < 9; i++) tick(1'b1, 300 + i, 1'b0, 1'b0);
    tick(1'b0, 0, 1'b1, 1'b0);            // full, push and pop together
    total++;
    if (stall !== 1'b1) begin bad++; $display("FAIL full_pp_stall: got %b want 1", stall); end
    tick(1'b0, 0, 1'b0, 1'b0);
    total++;
    if (ovf_flag !== 1'b0) begin bad++; $display("FAIL full_pp_ovf: got %b want 0", ovf_flag); end
    total++;
    if (tdata !== 16'd301) begin bad++; $display("FAIL full_pp_head: got %h want 012d", tdata); end
    drain();
  endtask

  task automatic test_flush_midframe();
    do_flush();
    prime(1'b0);
    for (int i = 0; i < 5; i++) tick(1'b1, (i == 2) ? 50000 : 600 + i, 1'b0, 1'b0);
    tick(1'b0, 0, 1'b0, 1'b0);
    tick(1'b0, 0, 1'b0, 1'b0);
    total++;
    if (sat_flag !== 1'b1 || tvalid !== 1'b1) begin
      bad++; $display("FAIL pre_flush: got sat=%b v=%b want 1 1", sat_flag, tvalid);
    end
    do_flush();
    tlast_seen = 0;
    for (int i = 0; i < PL; i++) tick(1'b1, 20000 + i, 1'b1, 1'b0);
    tick(1'b0, 0, 1'b1, 1'b0);
    tick(1'b0, 0, 1'b1, 1'b0);
    total++;
    if (tvalid !== 1'b0) begin bad++; $display("FAIL reprime_discard: got tvalid=%b want 0", tvalid); end
    for (int i = 0; i < FL; i++) tick(1'b1, 700 + i, 1'b1, 1'b0);
    drain();
    total++;
    if (tlast_seen !== 1) begin bad++; $display("FAIL flush_tlast: got %0d want 1", tlast_seen); end
  endtask

  initial begin
    test_reset();
    test_prime_latency();
    test_saturation();
    test_frames();
    test_backpressure();
    test_overflow();
    test_full_pushpop();
    test_flush_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
